tc_pcie_80bit_tx_gearbox: RTL and testbench

- Down-converter from an 80-bit word stream to a 10/20/40/80-bit lane stream, the transmit-side counterpart of the 80-bit RX converter.
- Accepts 80-bit words with a valid/ready handshake and serializes each word into 8/4/2/1 slices, least-significant slice first.
- A 10-bit word stream emitted by this block, fed into the RX converter, reassembles the original 80-bit words.
- Sits between the 80-bit PCS datapath and the PMA lane interface, in the rxclk_i domain.

---
 rtl/tc_pcie_80bit_tx_gearbox.sv | 119 +++++++++++
 tb/tb_tc_pcie_80bit_tx_gearbox.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tc_pcie_80bit_tx_gearbox.sv
// 80-bit word to 10/20/40/80-bit lane gearbox, transmit side.
// A one-entry hold stage feeds a shift stage so that back-to-back words serialize with no gap.
module tc_pcie_80bit_tx_gearbox #(
  parameter logic [79:0] IDLE_DATA = 80'd0
) (
  input  logic        rxclk_i,
  input  logic        reset_n_i,
  input  logic [1:0]  txwidth_i,
  input  logic [79:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [79:0] txdata_o,
  output logic        txvalid_o,
  output logic        word_start_o,
  output logic        underrun_o
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  typedef struct packed {
    logic [79:0] data;
    logic [1:0]  width;
    logic        vld;
  } hold_t;

  hold_t       hold_q;
  state_t      state_q, state_d;
  logic [79:0] shift_r, shift_d;
  logic [1:0]  width_r, width_d;
  logic [2:0]  cnt_r, cnt_d;
  logic        underrun_r, underrun_d;
  logic        active_r, last_c, load_c, accept_c;
  logic [2:0]  last_cnt;
  logic [6:0]  sh_amt;
  logic [79:0] mask;

  assign active_r = (state_q == SHIFT);
  // Last slice index is 7/3/1/0 for 10/20/40/80-bit lanes.
  assign last_cnt = 3'd7 >> width_r;
  assign last_c   = active_r & (cnt_r == last_cnt);
  assign load_c   = hold_q.vld & (~active_r | last_c);
  assign ready_o  = ~hold_q.vld | load_c;
  assign accept_c = valid_i & ready_o;

  always_comb begin
    sh_amt = 7'd10;
    mask   = 80'h3FF;
    case (width_r)
      2'd0: begin sh_amt = 7'd10; mask = 80'h3FF;           end
      2'd1: begin sh_amt = 7'd20; mask = 80'hF_FFFF;        end
      2'd2: begin sh_amt = 7'd40; mask = 80'hFF_FFFF_FFFF;  end
      default: begin sh_amt = 7'd80; mask = '1;            end
    endcase
  end

  always_ff @(posedge rxclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_q <= '0;
    end else if (accept_c) begin
      hold_q <= '{data: data_i, width: txwidth_i, vld: 1'b1};
    end else if (load_c) begin
      hold_q.vld <= 1'b0;
    end
  end

  always_ff @(posedge rxclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      shift_r    <= '0;
      width_r    <= '0;
      cnt_r      <= '0;
      underrun_r <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_r    <= shift_d;
      width_r    <= width_d;
      cnt_r      <= cnt_d;
      underrun_r <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_r;
    width_d    = width_r;
    cnt_d      = cnt_r;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_c) begin
          state_d = SHIFT;
          shift_d = hold_q.data;
          width_d = hold_q.width;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        if (!last_c) begin
          shift_d = shift_r >> sh_amt;
          cnt_d   = cnt_r + 3'd1;
        end else if (load_c) begin
          shift_d = hold_q.data;
          width_d = hold_q.width;
          cnt_d   = 3'd0;
        end else begin
          state_d    = IDLE;
          cnt_d      = 3'd0;
          underrun_d = 1'b1;
        end
      end
    endcase
  end

  assign txdata_o     = active_r ? (shift_r & mask) : IDLE_DATA;
  assign txvalid_o    = active_r;
  assign word_start_o = active_r & (cnt_r == 3'd0);
  assign underrun_o   = underrun_r;

endmodule

// File: tb/tb_tc_pcie_80bit_tx_gearbox.sv
// Directed bench for the 80-bit TX gearbox, including a 20-bit loopback reassembler.
module tb_tc_pcie_80bit_tx_gearbox;

  logic        rxclk_i = 1'b0;
  logic        reset_n_i;
  logic [1:0]  txwidth_i;
  logic [79:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [79:0] txdata_o;
  logic        txvalid_o;
  logic        word_start_o;
  logic        underrun_o;

  int tests = 0;
  int fails = 0;

  tc_pcie_80bit_tx_gearbox dut (
    .rxclk_i      (rxclk_i),
    .reset_n_i    (reset_n_i),
    .txwidth_i    (txwidth_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .txdata_o     (txdata_o),
    .txvalid_o    (txvalid_o),
    .word_start_o (word_start_o),
    .underrun_o   (underrun_o)
  );

  always #5 rxclk_i = ~rxclk_i;

  task automatic step();
    @(posedge rxclk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RX-side model: reassembles 20-bit slices into 80-bit words.
  logic        lb_en = 1'b0;
  int          lb_pos = 0;
  logic [79:0] lb_acc = '0;
  logic [79:0] rxq[$];

  always @(negedge rxclk_i) begin
    if (lb_en && txvalid_o) begin
      lb_pos = word_start_o ? 0 : lb_pos + 1;
      lb_acc[lb_pos*20 +: 20] = txdata_o[19:0];
      if (lb_pos == 3) rxq.push_back(lb_acc);
    end
  end

  logic [79:0] wa, wb, wc, wd, we, wf;
  logic [79:0] g [4];
  logic        acc_now;
  int          guard;

  initial begin
    reset_n_i = 1'b0; txwidth_i = 2'd0; data_i = '0; valid_i = 1'b0;
    #12;
    chk("rst_ready",    80'(ready_o),      80'd1);
    chk("rst_txvalid",  80'(txvalid_o),    80'd0);
    chk("rst_txdata",   txdata_o,          80'd0);
    chk("rst_wstart",   80'(word_start_o), 80'd0);
    chk("rst_underrun", 80'(underrun_o),   80'd0);
    reset_n_i = 1'b1;
    step();

    // Width 0, single word
    wa = 80'h9876_5432_10FE_DCBA_0123;
    data_i = wa; txwidth_i = 2'd0; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("w0_pre_txvalid", 80'(txvalid_o), 80'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("w0_slice%0d", i), txdata_o, {70'd0, wa[10*i +: 10]});
      chk($sformatf("w0_ws%0d", i), 80'(word_start_o), 80'(i == 0));
      chk($sformatf("w0_vld%0d", i), 80'(txvalid_o), 80'd1);
      chk($sformatf("w0_ur%0d", i), 80'(underrun_o), 80'd0);
      if (i == 0) chk("w0_slice0_lit", txdata_o, 80'h123);
    end
    step();
    chk("w0_underrun", 80'(underrun_o), 80'd1);
    chk("w0_idle_vld", 80'(txvalid_o),  80'd0);
    chk("w0_idle_dat", txdata_o,        80'd0);
    step();
    chk("w0_underrun_off", 80'(underrun_o), 80'd0);

    // Width 3, full-throughput stream of 1..16
    data_i = 80'd1; txwidth_i = 2'd3; valid_i = 1'b1;
    step();
    chk("w3_ready0", 80'(ready_o), 80'd1);
    data_i = 80'd2;
    for (int j = 1; j <= 16; j++) begin
      step();
      chk($sformatf("w3_data%0d", j), txdata_o, 80'(j));
      chk($sformatf("w3_vld%0d", j), 80'(txvalid_o), 80'd1);
      chk($sformatf("w3_ready%0d", j), 80'(ready_o), 80'd1);
      chk($sformatf("w3_ur%0d", j), 80'(underrun_o), 80'd0);
      if (j < 15) data_i = 80'(j + 2);
      else valid_i = 1'b0;
    end
    step();
    chk("w3_underrun", 80'(underrun_o), 80'd1);

    // Width 2, two words back-to-back with backpressure
    wb = 80'hAAAA_1111_2222_3333_4444;
    wc = 80'h5555_6666_7777_8888_9999;
    data_i = wb; txwidth_i = 2'd2; valid_i = 1'b1;
    step();
    chk("w2_ready_a", 80'(ready_o), 80'd1);
    data_i = wc;
    step();
    valid_i = 1'b0;
    chk("w2_ready_full", 80'(ready_o), 80'd0);
    chk("w2_s0", txdata_o, {40'd0, wb[39:0]});
    chk("w2_ws0", 80'(word_start_o), 80'd1);
    step();
    chk("w2_ready_drain", 80'(ready_o), 80'd1);
    chk("w2_s1", txdata_o, {40'd0, wb[79:40]});
    chk("w2_ws1", 80'(word_start_o), 80'd0);
    step();
    chk("w2_s2", txdata_o, {40'd0, wc[39:0]});
    chk("w2_ws2", 80'(word_start_o), 80'd1);
    chk("w2_vld2", 80'(txvalid_o), 80'd1);
    step();
    chk("w2_s3", txdata_o, {40'd0, wc[79:40]});
    chk("w2_ws3", 80'(word_start_o), 80'd0);
    step();
    chk("w2_underrun", 80'(underrun_o), 80'd1);
    chk("w2_idle", 80'(txvalid_o), 80'd0);

    // Width change after acceptance: 0 then 1, later changes ignored
    wd = 80'h0F1E_2D3C_4B5A_6978_8796;
    we = 80'hFEDC_BA98_7654_3210_ABCD;
    data_i = wd; txwidth_i = 2'd0; valid_i = 1'b1;
    step();
    data_i = we; txwidth_i = 2'd1;
    step();
    valid_i = 1'b0; txwidth_i = 2'd3;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk($sformatf("wc_d%0d", i), txdata_o, {70'd0, wd[10*i +: 10]});
      chk($sformatf("wc_rdy%0d", i), 80'(ready_o), 80'(i == 7));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("wc_e%0d", i), txdata_o, {60'd0, we[20*i +: 20]});
      chk($sformatf("wc_ews%0d", i), 80'(word_start_o), 80'(i == 0));
    end
    step();
    chk("wc_underrun", 80'(underrun_o), 80'd1);

    // Reset at slice 3 of a width-0 word
    data_i = wd; txwidth_i = 2'd0; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mr_pre_slice3", txdata_o, {70'd0, wd[39:30]});
    reset_n_i = 1'b0;
    #1;
    chk("mr_txvalid", 80'(txvalid_o),    80'd0);
    chk("mr_txdata",  txdata_o,          80'd0);
    chk("mr_ready",   80'(ready_o),      80'd1);
    chk("mr_ws",      80'(word_start_o), 80'd0);
    chk("mr_ur",      80'(underrun_o),   80'd0);
    #2;
    reset_n_i = 1'b1;
    step();
    chk("mr_post_idle", 80'(txvalid_o), 80'd0);
    wf = 80'h1357_9BDF_0246_8ACE_1122;
    data_i = wf; txwidth_i = 2'd0; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    chk("mr_new_s0", txdata_o, {70'd0, wf[9:0]});
    chk("mr_new_ws", 80'(word_start_o), 80'd1);
    step();
    chk("mr_new_s1", txdata_o, {70'd0, wf[19:10]});
    for (int i = 0; i < 8; i++) step();
    chk("mr_drained", 80'(txvalid_o), 80'd0);

    // Loopback at width 1
    g[0] = 80'h0123_4567_89AB_CDEF_0011;
    g[1] = 80'hFFEE_DDCC_BBAA_9988_7766;
    g[2] = 80'h8000_0000_0000_0000_0001;
    g[3] = 80'h5A5A_A5A5_3C3C_C3C3_0F0F;
    lb_en = 1'b1;
    txwidth_i = 2'd1;
    for (int n = 0; n < 4; n++) begin
      data_i = g[n]; valid_i = 1'b1;
      guard = 0;
      do begin
        acc_now = ready_o;
        step();
        guard++;
      end while (!acc_now && guard < 50);
    end
    valid_i = 1'b0;
    guard = 0;
    while (rxq.size() < 4 && guard < 200) begin
      step();
      guard++;
    end
    chk("lb_count", 80'(rxq.size()), 80'd4);
    for (int n = 0; n < 4; n++) begin
      if (n < rxq.size()) chk($sformatf("lb_word%0d", n), rxq[n], g[n]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
